bmp_master_receiver: RTL and testbench
======================================

Name: bmp_master_receiver

Overview:
- Master-side endpoint of the BMP arbiter's master port. It consumes the word stream the arbiter drives toward master 0 and owns the mstr0_ready backpressure.
- Buffers words in a small FWFT FIFO, tags the frame's last word, and forwards them on a valid/ready stream to the downstream writer.
- Computes a per-frame word count and 32-bit additive checksum. Reports frame completion once mstr0_cmplt is seen and the buffer has drained.

Parameters:
- DATA_BUS_SIZE, 32, width of data_to_master and out_data.
- FIFO_DEPTH, 8, entries in the internal buffer; power of two, minimum 4.
- CNT_W, 16, width of the frame word counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- data_to_master  input  DATA_BUS_SIZE  word from the arbiter.
- mstr0_data_valid  input  2  00 idle, 01 data word, 11 last word of frame, 10 reserved (protocol error).
- mstr0_cmplt  input  1  single-cycle pulse from the arbiter: transfer complete.
- mstr0_ready  output  1  receiver can accept a word this cycle.
- out_data  output  DATA_BUS_SIZE  FIFO head word.
- out_last  output  1  head word is the frame's last word.
- out_valid  output  1  head word is valid.
- out_ready  input  1  downstream accepts the head word.
- frame_done  output  1  one-cycle pulse: frame fully delivered.
- frame_words  output  CNT_W  words accepted in the frame; held until the next frame starts.
- frame_sum  output  DATA_BUS_SIZE  modulo-2^DATA_BUS_SIZE sum of the accepted words; held until the next frame starts.
- err_proto  output  1  sticky protocol error; cleared when the next frame starts.

Behaviour:
- Reset (async, rst=1) forces the following, and the FIFO is flushed:
  - mstr0_ready=0, out_valid=0, out_last=0, out_data=0
  - frame_done=0, frame_words=0, frame_sum=0, err_proto=0
  - state=IDLE
- mstr0_ready is registered and asserts on the first clk edge after rst falls. A reset mid-frame discards the frame and produces no frame_done.
- Word transfer occurs at a clk edge where mstr0_ready=1 and mstr0_data_valid is 01 or 11. Code 10 never writes the FIFO; it sets err_proto.
- Backpressure: mstr0_ready registered as (count_next <= FIFO_DEPTH-2) and state in {IDLE, RECV}. Because of this the FIFO can never overflow, including when a push and a pop happen in the same cycle.
- FIFO entries are DATA_BUS_SIZE+1 bits: {last, data}.
  - out_valid = !empty, FWFT: the head is visible with no read latency.
  - Pop on out_valid && out_ready.
  - A simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Counters:
  - frame_words increments per accepted word and saturates at 2^CNT_W-1.
  - frame_sum adds each accepted word, wrapping.
  - The first accepted word of a frame loads words=1 and sum=word. Both counters and err_proto clear only at that point.
- State machine:
  - IDLE: accepted word -> RECV (11 counts as a one-word frame -> WAIT_CMPLT). mstr0_cmplt with no word -> DONE, with frame_words=0 and frame_sum=0.
  - RECV: accept words. Last word (11) -> WAIT_CMPLT. mstr0_cmplt without a prior 11 -> DRAIN, and the last FIFO entry is not retagged.
  - WAIT_CMPLT: mstr0_ready=0. mstr0_cmplt -> DRAIN. Any nonzero mstr0_data_valid here sets err_proto and is dropped.
  - 11 word and mstr0_cmplt in the same cycle: the word is accepted and the state goes directly to DRAIN.
  - DRAIN: mstr0_ready=0. When the FIFO is empty -> DONE.
  - DONE: frame_done=1 for exactly one cycle -> IDLE.
- mstr0_cmplt in DRAIN or DONE is ignored.
- No combinational path from any input to mstr0_ready. out_valid, out_data and out_last come from FIFO state and storage only.

Decomposition:
- Shared package bmp_pkg:
  - VLD_IDLE=2'b00, VLD_WORD=2'b01, VLD_RSVD=2'b10, VLD_LAST=2'b11
  - rx state encodings IDLE/RECV/WAIT_CMPLT/DRAIN/DONE
- Sub-module bmp_rx_fifo: parameterized width/depth FWFT FIFO with async active-high rst, count output, full/empty. The top holds the FSM, counters and ready logic.

Test Plan:
- Reset release, then 4 words 0x00000001..0x00000004 coded 01,01,01,11, cmplt one cycle after the last, out_ready=1 -> 4 outputs in order, out_last only on 0x4, frame_done pulse once, frame_words=4, frame_sum=0x0000000A.
- out_ready=0, 20 words offered continuously -> mstr0_ready drops after 7 accepted words (FIFO_DEPTH=8); no loss or duplication after out_ready=1; order preserved.
- Last word 0xFFFFFFFF and cmplt in the same cycle after 0x00000002 -> frame_sum=0x00000001, frame_words=2, goes straight to DRAIN.
- Code 10 during RECV -> err_proto=1, word not forwarded; err_proto clears on the first word of the next frame.
- Reset asserted mid-frame with 3 words buffered -> out_valid=0 immediately, no frame_done; the following frame is reported correctly.
- mstr0_cmplt in IDLE with no data -> frame_done pulse, frame_words=0, frame_sum=0.

Source files
------------

// File: rtl/bmp_pkg.sv
// Shared definitions for the BMP master-side receiver.
//   VLD_*      : encodings of the arbiter's 2-bit mstr0_data_valid field
//   rx_state_t : receiver frame-tracking states
//   is_word()  : true for codes that carry a word (data or last)
package bmp_pkg;

    localparam logic [1:0] VLD_IDLE = 2'b00;
    localparam logic [1:0] VLD_WORD = 2'b01;
    localparam logic [1:0] VLD_RSVD = 2'b10;
    localparam logic [1:0] VLD_LAST = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WAIT_CMPLT,
        DRAIN,
        DONE
    } rx_state_t;

    function automatic logic is_word(input logic [1:0] code);
        return (code == VLD_WORD) || (code == VLD_LAST);
    endfunction

endpackage

// File: rtl/bmp_rx_fifo.sv
// First-word-fall-through FIFO used as the receiver's word buffer.
//   clk, rst : clock, asynchronous active-high reset (flushes the FIFO)
//   push/din : write din when push=1 and not full
//   pop      : discard the head entry when pop=1 and not empty
//   dout     : head entry, visible with no read latency; zero when empty
//   count    : number of stored entries
//   full/empty: occupancy flags
module bmp_rx_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage is not reset; an empty FIFO masks the head to zero instead.
    assign dout = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bmp_master_receiver.sv
// Master-side endpoint of the BMP arbiter's master-0 port.
// Accepts the arbiter's word stream under mstr0_ready backpressure, buffers
// words tagged with a last flag, forwards them on a valid/ready stream and
// reports per-frame word count, additive checksum and protocol errors.
//   clk, rst          : clock, asynchronous active-high reset
//   data_to_master    : incoming word
//   mstr0_data_valid  : 00 idle, 01 word, 11 last word, 10 reserved
//   mstr0_cmplt       : transfer-complete pulse from the arbiter
//   mstr0_ready       : registered accept indication toward the arbiter
//   out_data/out_last/out_valid/out_ready : downstream FWFT stream
//   frame_done        : one-cycle pulse once the frame has fully drained
//   frame_words/frame_sum : frame statistics, held until the next frame
//   err_proto         : sticky protocol error, cleared on next frame start
module bmp_master_receiver
    import bmp_pkg::*;
#(
    parameter int DATA_BUS_SIZE = 32,
    parameter int FIFO_DEPTH    = 8,
    parameter int CNT_W         = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_BUS_SIZE-1:0] data_to_master,
    input  logic [1:0]               mstr0_data_valid,
    input  logic                     mstr0_cmplt,
    output logic                     mstr0_ready,
    output logic [DATA_BUS_SIZE-1:0] out_data,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     frame_done,
    output logic [CNT_W-1:0]         frame_words,
    output logic [DATA_BUS_SIZE-1:0] frame_sum,
    output logic                     err_proto
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] READY_MAX = CW'(FIFO_DEPTH - 2);

    rx_state_t state;
    rx_state_t state_next;

    logic                   accepting;
    logic                   push;
    logic                   pop;
    logic                   is_last;
    logic                   first_word;
    logic [CW-1:0]          fifo_count;
    logic [CW-1:0]          count_next;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [DATA_BUS_SIZE:0] head;

    bmp_rx_fifo #(
        .WIDTH (DATA_BUS_SIZE + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   ({is_last, data_to_master}),
        .pop   (pop),
        .dout  (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign is_last   = (mstr0_data_valid == VLD_LAST);
    assign push      = mstr0_ready && accepting && is_word(mstr0_data_valid) && !fifo_full;
    assign out_valid = !fifo_empty;
    assign out_data  = head[DATA_BUS_SIZE-1:0];
    assign out_last  = head[DATA_BUS_SIZE];
    assign pop       = out_valid && out_ready;

    assign count_next = fifo_count + CW'(push) - CW'(pop);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (push) begin
                    if (mstr0_cmplt) begin
                        state_next = DRAIN;
                    end else if (is_last) begin
                        state_next = WAIT_CMPLT;
                    end else begin
                        state_next = RECV;
                    end
                end else if (mstr0_cmplt) begin
                    state_next = DONE;
                end
            end
            RECV: begin
                if (mstr0_cmplt) begin
                    state_next = DRAIN;
                end else if (push && is_last) begin
                    state_next = WAIT_CMPLT;
                end
            end
            WAIT_CMPLT: begin
                if (mstr0_cmplt) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_empty) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State-decoded outputs
    always_comb begin
        frame_done = 1'b0;
        accepting  = 1'b0;
        first_word = 1'b0;
        case (state)
            IDLE: begin
                accepting  = 1'b1;
                first_word = push;
            end
            RECV: begin
                accepting = 1'b1;
            end
            DONE: begin
                frame_done = 1'b1;
            end
            default: begin
                accepting = 1'b0;
            end
        endcase
    end

    // Ready looks one cycle ahead: count_next already includes this cycle's
    // push and pop, so a word accepted on the next edge always fits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstr0_ready <= 1'b0;
        end else begin
            mstr0_ready <= (count_next <= READY_MAX) &&
                           ((state_next == IDLE) || (state_next == RECV));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_words <= '0;
            frame_sum   <= '0;
        end else if (first_word) begin
            frame_words <= CNT_W'(1);
            frame_sum   <= data_to_master;
        end else if (push) begin
            if (frame_words != '1) begin
                frame_words <= frame_words + CNT_W'(1);
            end
            frame_sum <= frame_sum + data_to_master;
        end else if ((state == IDLE) && mstr0_cmplt) begin
            // Empty frame: report zero statistics.
            frame_words <= '0;
            frame_sum   <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_proto <= 1'b0;
        end else if (first_word) begin
            err_proto <= 1'b0;
        end else if (((state == IDLE) || (state == RECV)) &&
                     (mstr0_data_valid == VLD_RSVD)) begin
            err_proto <= 1'b1;
        end else if ((state == WAIT_CMPLT) && (mstr0_data_valid != VLD_IDLE)) begin
            err_proto <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bmp_master_receiver.sv
// Scoreboard bench for bmp_master_receiver: stimulus pushes expected output
// words and frame reports into queues; a monitor pops and compares them.
module tb_bmp_master_receiver;
    import bmp_pkg::*;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] data_to_master = '0;
    logic [1:0]    mstr0_data_valid = 2'b00;
    logic          mstr0_cmplt = 1'b0;
    logic          mstr0_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          frame_done;
    logic [15:0]   frame_words;
    logic [DW-1:0] frame_sum;
    logic          err_proto;

    typedef struct {
        logic [15:0]   words;
        logic [DW-1:0] sum;
        logic          err;
    } frame_t;

    logic [DW:0] exp_q [$];
    frame_t      frm_q [$];

    int checks = 0;
    int errors = 0;

    bmp_master_receiver #(
        .DATA_BUS_SIZE (DW),
        .FIFO_DEPTH    (8),
        .CNT_W         (16)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .data_to_master   (data_to_master),
        .mstr0_data_valid (mstr0_data_valid),
        .mstr0_cmplt      (mstr0_cmplt),
        .mstr0_ready      (mstr0_ready),
        .out_data         (out_data),
        .out_last         (out_last),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .frame_done       (frame_done),
        .frame_words      (frame_words),
        .frame_sum        (frame_sum),
        .err_proto        (err_proto)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Monitor: sample mid-cycle, after the negedge drive point.
    initial begin
        logic [DW:0] e;
        frame_t      f;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        fail_now($sformatf("unexpected_out got 0x%0h last %0b", out_data, out_last));
                    end else begin
                        e = exp_q.pop_front();
                        check("out_word", {31'b0, out_last, out_data}, {31'b0, e});
                    end
                end
                if (frame_done) begin
                    if (frm_q.size() == 0) begin
                        fail_now("unexpected_frame_done");
                    end else begin
                        f = frm_q.pop_front();
                        check("frame_words", 64'(frame_words), 64'(f.words));
                        check("frame_sum", 64'(frame_sum), 64'(f.sum));
                        check("frame_err", 64'(err_proto), 64'(f.err));
                    end
                end
            end
        end
    end

    // Called at a negedge; holds the word until mstr0_ready accepts it.
    task automatic send(input logic [DW-1:0] d, input logic [1:0] code,
                        input bit cm, input bit track);
        int n = 0;
        data_to_master   = d;
        mstr0_data_valid = code;
        mstr0_cmplt      = cm;
        while (!mstr0_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!mstr0_ready) begin
            fail_now("send_timeout");
        end else if (track) begin
            exp_q.push_back({(code == VLD_LAST), d});
        end
        @(negedge clk);
        mstr0_data_valid = VLD_IDLE;
        mstr0_cmplt      = 1'b0;
    endtask

    task automatic pulse_cmplt();
        mstr0_cmplt = 1'b1;
        @(negedge clk);
        mstr0_cmplt = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!(exp_q.size() == 0 && frm_q.size() == 0 && mstr0_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 500) begin
            errors++;
            $display("FAIL %s: pending words %0d, pending frames %0d, ready %0b",
                     name, exp_q.size(), frm_q.size(), mstr0_ready);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;

        // Reset values
        #1;
        check("rst_ready", 64'(mstr0_ready), 64'd0);
        check("rst_out", {29'b0, out_valid, out_last, frame_done, out_data}, 64'd0);
        check("rst_stats", {frame_words, frame_sum}, 64'd0);
        check("rst_err", 64'(err_proto), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_before_edge", 64'(mstr0_ready), 64'd0);
        @(negedge clk);
        check("ready_after_release", 64'(mstr0_ready), 64'd1);

        // Basic four-word frame, cmplt one cycle after the last word
        out_ready = 1'b1;
        frm_q.push_back('{words: 16'd4, sum: 32'h0000000A, err: 1'b0});
        send(32'h1, VLD_WORD, 1'b0, 1'b1);
        send(32'h2, VLD_WORD, 1'b0, 1'b1);
        send(32'h3, VLD_WORD, 1'b0, 1'b1);
        send(32'h4, VLD_LAST, 1'b0, 1'b1);
        pulse_cmplt();
        wait_idle("frame_basic_done");

        // Backpressure: downstream stalled, words offered every cycle
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            data_to_master   = 32'h100 + 32'(acc + 1);
            mstr0_data_valid = VLD_WORD;
            if (mstr0_ready) begin
                exp_q.push_back({1'b0, data_to_master});
                acc++;
            end
            @(negedge clk);
        end
        mstr0_data_valid = VLD_IDLE;
        check("bp_accepted", 64'(acc), 64'd7);
        check("bp_ready_low", 64'(mstr0_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        frm_q.push_back('{words: 16'd20, sum: 32'h000014D2, err: 1'b0});
        out_ready = 1'b1;
        for (int i = acc + 1; i <= 20; i++) begin
            send(32'h100 + 32'(i), (i == 20) ? VLD_LAST : VLD_WORD, 1'b0, 1'b1);
        end
        pulse_cmplt();
        wait_idle("frame_bp_done");

        // Last word together with cmplt, sum wraps
        frm_q.push_back('{words: 16'd2, sum: 32'h00000001, err: 1'b0});
        send(32'h2, VLD_WORD, 1'b0, 1'b1);
        send(32'hFFFFFFFF, VLD_LAST, 1'b1, 1'b1);
        wait_idle("frame_last_cmplt_done");

        // Reserved code mid-frame
        frm_q.push_back('{words: 16'd2, sum: 32'h00000021, err: 1'b1});
        send(32'h10, VLD_WORD, 1'b0, 1'b1);
        data_to_master   = 32'hDEADBEEF;
        mstr0_data_valid = VLD_RSVD;
        @(negedge clk);
        mstr0_data_valid = VLD_IDLE;
        check("err_set", 64'(err_proto), 64'd1);
        send(32'h11, VLD_LAST, 1'b0, 1'b1);
        pulse_cmplt();
        wait_idle("frame_err_done");
        check("err_held", 64'(err_proto), 64'd1);
        frm_q.push_back('{words: 16'd2, sum: 32'h0000000B, err: 1'b0});
        send(32'h5, VLD_WORD, 1'b0, 1'b1);
        check("err_cleared", 64'(err_proto), 64'd0);
        send(32'h6, VLD_LAST, 1'b0, 1'b1);
        pulse_cmplt();
        wait_idle("frame_after_err_done");

        // Reset mid-frame with three words buffered
        out_ready = 1'b0;
        send(32'h21, VLD_WORD, 1'b0, 1'b0);
        send(32'h22, VLD_WORD, 1'b0, 1'b0);
        send(32'h23, VLD_WORD, 1'b0, 1'b0);
        check("mid_buffered", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_ready", 64'(mstr0_ready), 64'd0);
        check("mid_rst_stats", {frame_words, frame_sum}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        frm_q.push_back('{words: 16'd2, sum: 32'h0000000F, err: 1'b0});
        send(32'h7, VLD_WORD, 1'b0, 1'b1);
        send(32'h8, VLD_LAST, 1'b0, 1'b1);
        pulse_cmplt();
        wait_idle("frame_after_rst_done");

        // cmplt in IDLE with no data: empty frame report
        frm_q.push_back('{words: 16'd0, sum: 32'h0, err: 1'b0});
        pulse_cmplt();
        wait_idle("frame_empty_done");

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
